// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: dual-word fetch-to-decode circular queue (ports: clk, rst, flush, fetch_* in, deq_num in, hold_pc/inst2_taken/out_* out); define INST_BUF_BYPASS_EN for same-cycle bypass when empty
module inst_fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst1,
  input  logic [31:0] fetch_inst2,
  input  logic        fetch_inst2_valid,
  input  logic [1:0]  deq_num,
  output logic        hold_pc,
  output logic        inst2_taken,
  output logic        out_valid1,
  output logic        out_valid2,
  output logic [31:0] out_pc1,
  output logic [31:0] out_pc2,
  output logic [31:0] out_inst1,
  output logic [31:0] out_inst2
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head, tail, head1, tail1;
  logic [AW:0] count;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic acc;
  logic [1:0] enq, deq_req, deq, skip, wr_n;
  logic [31:0] w0_pc, w0_inst;
  assign hold_pc = count >= (AW+1)'(DEPTH - 1);
  assign acc = fetch_valid & ~hold_pc & ~flush & ~rst;
  assign inst2_taken = acc & fetch_inst2_valid;
  assign enq = acc ? (fetch_inst2_valid ? 2'd2 : 2'd1) : 2'd0;
  assign deq_req = deq_num == 2'd3 ? 2'd2 : deq_num;
  assign deq = (AW+1)'(deq_req) > count ? count[1:0] : deq_req;
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
`ifdef INST_BUF_BYPASS_EN
  logic byp;
  assign byp = acc & (count == '0);
  assign skip = byp ? (deq_req < enq ? deq_req : enq) : 2'd0;
  assign out_valid1 = byp | (count != '0);
  assign out_valid2 = byp ? fetch_inst2_valid : count >= (AW+1)'(2);
  assign out_pc1 = byp ? fetch_pc : pc_mem[head];
  assign out_inst1 = byp ? fetch_inst1 : inst_mem[head];
  assign out_pc2 = byp ? fetch_pc + 32'd4 : pc_mem[head1];
  assign out_inst2 = byp ? fetch_inst2 : inst_mem[head1];
`else
  assign skip = 2'd0;
  assign out_valid1 = count != '0;
  assign out_valid2 = count >= (AW+1)'(2);
  assign out_pc1 = pc_mem[head];
  assign out_inst1 = inst_mem[head];
  assign out_pc2 = pc_mem[head1];
  assign out_inst2 = inst_mem[head1];
`endif
  assign wr_n = enq - skip;
  assign w0_pc = skip == 2'd1 ? fetch_pc + 32'd4 : fetch_pc;
  assign w0_inst = skip == 2'd1 ? fetch_inst2 : fetch_inst1;
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) begin
      pc_mem[tail] <= w0_pc;
      inst_mem[tail] <= w0_inst;
    end
    if (wr_n == 2'd2) begin
      pc_mem[tail1] <= fetch_pc + 32'd4;
      inst_mem[tail1] <= fetch_inst2;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(wr_n);
      count <= count + (AW+1)'(wr_n) - (AW+1)'(deq);
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: randomized scoreboard bench against a queue-based model of the fetch buffer
module tb_inst_fetch_buffer;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, fetch_valid = 1'b0, fetch_inst2_valid = 1'b0;
  logic [31:0] fetch_pc = '0, fetch_inst1 = '0, fetch_inst2 = '0;
  logic [1:0] deq_num = '0;
  logic hold_pc, inst2_taken, out_valid1, out_valid2;
  logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2), .fetch_inst2_valid(fetch_inst2_valid),
    .deq_num(deq_num), .hold_pc(hold_pc), .inst2_taken(inst2_taken), .out_valid1(out_valid1),
    .out_valid2(out_valid2), .out_pc1(out_pc1), .out_pc2(out_pc2), .out_inst1(out_inst1), .out_inst2(out_inst2)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit chk, hold, taken, v1, v2;
    logic [31:0] pc1, i1, pc2, i2;
  } exp_t;
  exp_t exp_q[$];
  logic [63:0] mq[$];
  bit known = 1'b0;
  int n_chk = 0, n_pass = 0;
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp("hold_pc", 32'(hold_pc), 32'(e.hold));
          cmp("inst2_taken", 32'(inst2_taken), 32'(e.taken));
          cmp("out_valid1", 32'(out_valid1), 32'(e.v1));
          cmp("out_valid2", 32'(out_valid2), 32'(e.v2));
          if (e.v1) begin
            cmp("out_pc1", out_pc1, e.pc1);
            cmp("out_inst1", out_inst1, e.i1);
          end
          if (e.v2) begin
            cmp("out_pc2", out_pc2, e.pc2);
            cmp("out_inst2", out_inst2, e.i2);
          end
        end
      end
    end
  end
  task automatic cyc(input bit r, input bit f, input bit fv, input logic [31:0] pc, input bit v2, input logic [1:0] dn);
    exp_t e;
    int d, sz;
    @(negedge clk);
    rst = r; flush = f; fetch_valid = fv; fetch_pc = pc; fetch_inst2_valid = v2; deq_num = dn;
    fetch_inst1 = $urandom; fetch_inst2 = $urandom;
    sz = mq.size();
    e.chk = known;
    e.hold = sz >= DEPTH - 1;
    e.taken = !r && !f && fv && v2 && !e.hold;
    e.v1 = sz >= 1;
    e.v2 = sz >= 2;
    e.pc1 = sz >= 1 ? mq[0][63:32] : 32'd0;
    e.i1 = sz >= 1 ? mq[0][31:0] : 32'd0;
    e.pc2 = sz >= 2 ? mq[1][63:32] : 32'd0;
    e.i2 = sz >= 2 ? mq[1][31:0] : 32'd0;
    exp_q.push_back(e);
    if (r || f) begin
      mq.delete();
      if (r) known = 1'b1;
    end else begin
      d = dn == 2'd3 ? 2 : int'(dn);
      if (d > sz) d = sz;
      repeat (d) void'(mq.pop_front());
      if (fv && !e.hold) begin
        mq.push_back({pc, fetch_inst1});
        if (v2) mq.push_back({pc + 32'd4, fetch_inst2});
      end
    end
  endtask
  initial begin
    bit r, f, fv, v2;
    logic [1:0] dn;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hbfc00000, 1, 0);
    for (int i = 1; i < 5; i++) cyc(0, 0, 1, 32'hbfc00000 + 32'(8 * i), 1, 0);
    cyc(0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0, 1);
    for (int i = 1; i < 7; i++) cyc(0, 0, 1, 32'h40 + 32'(4 * i), 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h100, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h200, 1, 0);
    cyc(0, 0, 1, 32'h208, 1, 0);
    cyc(0, 0, 1, 32'h210, 0, 0);
    cyc(0, 1, 1, 32'h300, 1, 2);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h400, 0, 0);
    cyc(0, 0, 1, 32'h500, 0, 3);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199) == 0;
      f = $urandom_range(0, 39) == 0;
      fv = $urandom_range(0, 3) != 0;
      v2 = $urandom_range(0, 2) != 0;
      dn = (i % 400 < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      cyc(r, f, fv, $urandom & 32'hffff_fffc, v2, dn);
    end
    repeat (3) @(negedge clk);
    #4;
    cmp("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
